// File: rtl/spi_read_master.sv
// spi_read_master: single-lane SPI mode-0 read initiator.
// Sends cmd+addr MSB-first, then streams received bytes out.
module spi_read_master #(
  parameter int CLK_DIV = 2,
  parameter int LEN_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [7:0]       req_cmd,
  input  logic [23:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  output logic             rd_valid,
  output logic [7:0]       rd_data,
  input  logic             rd_ready,
  output logic             busy,
  output logic             spi_sck,
  output logic             spi_cs_n,
  output logic             spi_mosi,
  input  logic             spi_miso
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = LEN_W + 4;
  localparam logic [CW-1:0] CMAX = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] HDR = BW'(32);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    STALL,
    HOLD
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bits;
  logic [BW-1:0]    total;
  logic [LEN_W-1:0] len_q;
  logic [31:0]      sr;
  logic [7:0]       rx;
  logic             done_byte;
  logic             sck_q;
  logic             cs_q;
  logic             tick;
  logic             in_data;
  logic             byte_edge;
  logic             stall_now;

  assign tick      = (cnt == CMAX);
  assign total     = HDR + BW'({len_q, 3'b000});
  assign in_data   = (bits >= HDR);
  assign byte_edge = in_data && (bits[2:0] == 3'd0);
  assign stall_now = byte_edge && rd_valid && !rd_ready;

  assign req_ready = (state == IDLE) && !rd_valid;
  assign spi_sck   = sck_q;
  assign spi_cs_n  = cs_q;
  // sr shifts in zeros, so its MSB is 0 in the data phase
  assign spi_mosi  = sr[31];

  // Transfer sequencer: SPI pins, bit timing and byte output
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bits      <= '0;
      len_q     <= '0;
      sr        <= '0;
      rx        <= '0;
      done_byte <= 1'b0;
      sck_q     <= 1'b0;
      cs_q      <= 1'b1;
      busy      <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      done_byte <= 1'b0;
      if (done_byte) begin
        rd_data  <= rx;
        rd_valid <= 1'b1;
      end else if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            sr    <= {req_cmd, req_addr};
            len_q <= req_len;
            bits  <= '0;
            cnt   <= '0;
            cs_q  <= 1'b0;
            busy  <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (tick) begin
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (!sck_q) begin
            if (!tick) begin
              cnt <= cnt + 1'b1;
            end else if (stall_now) begin
              cnt   <= '0;
              state <= STALL;
            end else begin
              cnt   <= '0;
              sck_q <= 1'b1;
              bits  <= bits + 1'b1;
              rx    <= {rx[6:0], spi_miso};
              if (in_data && bits[2:0] == 3'd7) begin
                done_byte <= 1'b1;
              end
            end
          end else begin
            if (!tick) begin
              cnt <= cnt + 1'b1;
            end else begin
              cnt   <= '0;
              sck_q <= 1'b0;
              sr    <= {sr[30:0], 1'b0};
              if (bits == total) begin
                state <= HOLD;
              end
            end
          end
        end
        STALL: begin
          if (!rd_valid || rd_ready) begin
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        HOLD: begin
          if (tick) begin
            cnt   <= '0;
            cs_q  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
